chaos_sbox_builder: RTL
=======================

// Module: chaos_sbox_builder
// PURPOSE
//  Builds a bijective substitution table from a stream of chaotic-map candidate bytes, then serves lookups.
//  - Duplicate candidates are rejected, so the finished table is always a permutation of 0..DEPTH-1.
//  - Sits between the chaotic sequence generator and the pixel substitution stage.
//  - Parametrised successor of the fixed 8-bit, fixed-count table loader.
// PARAMETERS
//  ADDR_W   8    index/value width; DEPTH = 2**ADDR_W entries, every value ADDR_W bits
//  CNT_W    16   width of the duplicate-reject counter (saturating)
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous active-high reset
//  start          in   1       begin or restart a table build (single-cycle pulse)
//  cand_valid     in   1       candidate value offered
//  cand_data      in   ADDR_W  candidate value from the chaotic generator
//  cand_ready     out  1       candidate consumed this cycle when cand_valid && cand_ready
//  dup_drop       out  1       one-cycle pulse: the consumed candidate was a duplicate and was discarded
//  dup_count      out  CNT_W   duplicates discarded in the current build, saturating
//  busy           out  1       high in LOAD state
//  done_sbox      out  1       high in READY state (table complete and bijective)
//  lookup_valid   in   1       lookup request
//  lookup_inv     in   1       1 = inverse table (only with INV_SBOX_EN; ignored otherwise)
//  lookup_addr    in   ADDR_W  lookup index
//  lookup_rdata   out  ADDR_W  lookup result
//  lookup_rvalid  out  1       lookup_rdata valid
// BEHAVIOUR
//  States: IDLE -> LOAD on start; LOAD -> READY on the DEPTH-th unique accept; READY -> LOAD on start.
//  - start in any state (including LOAD mid-build) -> LOAD, clearing index, seen bitmap and dup_count.
//  Reset: state=IDLE; cand_ready, dup_drop, busy, done_sbox, lookup_rvalid = 0; dup_count=0; lookup_rdata=0.
//  - Reset clears the index and the seen bitmap. Table RAM contents are not cleared.
//  cand_ready = (state==LOAD) && !start (combinational). start wins over a same-cycle candidate; that candidate is not consumed.
//  On consume, value v:
//  - seen[v]==0 -> mem[index]<=v, seen[v]<=1, index<=index+1.
//  - seen[v]==1 -> no write; dup_drop pulses the next cycle; dup_count++ unless at all-ones.
//  Completion: a unique accept at index==DEPTH-1 -> state READY next cycle.
//  - done_sbox and busy are registered state decodes; done_sbox rises one cycle after the final write.
//  - index wraps to 0 at completion.
//  Lookup: honoured only in READY.
//  - lookup_valid at edge N -> lookup_rdata = mem[lookup_addr] with lookup_rvalid=1 after edge N+1 (1-cycle latency).
//  - Back-to-back requests give back-to-back results.
//  - In IDLE/LOAD, requests are dropped: lookup_rvalid=0 and lookup_rdata holds its value.
//  - A start in the cycle after a READY request still returns that result.
//  Read and write never coincide: writes occur only in LOAD, reads only in READY.
// CONFIGURATION
//  INV_SBOX_EN defined:
//  - Second RAM inv_mem; every unique accept also writes inv_mem[v] <= index.
//  - lookup_inv=1 reads inv_mem with the same latency.
//  - Guarantees inv[fwd[x]]==x once done_sbox.
//  INV_SBOX_EN undefined: no inv_mem; lookup_inv ignored; lookups always read the forward table.
// TESTING (ADDR_W=4 unless stated)
//  1. rst, start, feed 15,14,..,0 with cand_valid held
//     -> cand_ready=1 for 16 cycles, done_sbox=1 one cycle after the 16th; lookup 3 -> 12 one cycle later.
//  2. start, feed 5,5,7,5,...
//     -> dup_drop pulses for the 2nd and 4th values; dup_count=2; index advances only on 5 and 7.
//  3. After 9 unique accepts, pulse start
//     -> busy stays 1, dup_count=0; a fresh 16-value sequence completes normally with no stale entries.
//  4. start and cand_valid in the same cycle with data 9
//     -> cand_ready=0, 9 not written; offering 9 on the next cycle is accepted as unique.
//  5. lookup_valid in LOAD -> lookup_rvalid stays 0; in READY, 3 back-to-back lookups -> 3 consecutive rvalid cycles.
//  6. INV_SBOX_EN, ADDR_W=8, 256 LFSR-driven candidates with duplicates
//     -> done_sbox=1; for all x, inv lookup of fwd lookup of x == x.

Source files
------------

// File: rtl/chaos_sbox_builder.sv
// Builds a bijective substitution table from chaotic candidate bytes and serves lookups from it.
// Optional feature macro: INV_SBOX_EN adds an inverse table readable through lookup_inv.
module chaos_sbox_builder #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cand_valid,
  input  logic [ADDR_W-1:0] cand_data,
  output logic              cand_ready,
  output logic              dup_drop,
  output logic [CNT_W-1:0]  dup_count,
  output logic              busy,
  output logic              done_sbox,
  input  logic              lookup_valid,
  input  logic              lookup_inv,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic [ADDR_W-1:0] lookup_rdata,
  output logic              lookup_rvalid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [DEPTH-1:0]  seen;
  logic [ADDR_W-1:0] fwd_mem [DEPTH];
  logic [ADDR_W-1:0] rd_word;

  logic consume;
  logic is_dup;
  logic accept;
  logic lookup_hit;

  // start takes priority, so a candidate offered alongside it is never consumed
  assign cand_ready = (state == LOAD) && !start;
  assign consume    = cand_valid && cand_ready;
  assign is_dup     = seen[cand_data];
  assign accept     = consume && !is_dup && !rst;
  assign lookup_hit = (state == READY) && lookup_valid;

  always_ff @(posedge clk) begin
    if (accept) begin
      fwd_mem[index] <= cand_data;
    end
  end

`ifdef INV_SBOX_EN
  logic [ADDR_W-1:0] inv_mem [DEPTH];

  // Each unique accept also records where its value landed, so inv[fwd[x]] == x on completion
  always_ff @(posedge clk) begin
    if (accept) begin
      inv_mem[cand_data] <= index;
    end
  end

  assign rd_word = lookup_inv ? inv_mem[lookup_addr] : fwd_mem[lookup_addr];
`else
  logic unused_lookup_inv;

  assign unused_lookup_inv = lookup_inv;
  assign rd_word           = fwd_mem[lookup_addr];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      index         <= '0;
      seen          <= '0;
      dup_drop      <= 1'b0;
      dup_count     <= '0;
      busy          <= 1'b0;
      done_sbox     <= 1'b0;
      lookup_rvalid <= 1'b0;
      lookup_rdata  <= '0;
    end else begin
      dup_drop      <= 1'b0;
      lookup_rvalid <= 1'b0;

      if (lookup_hit) begin
        lookup_rvalid <= 1'b1;
        lookup_rdata  <= rd_word;
      end

      if (start) begin
        state     <= LOAD;
        busy      <= 1'b1;
        done_sbox <= 1'b0;
        index     <= '0;
        seen      <= '0;
        dup_count <= '0;
      end else if (consume) begin
        if (is_dup) begin
          dup_drop <= 1'b1;
          if (dup_count != {CNT_W{1'b1}}) begin
            dup_count <= dup_count + 1'b1;
          end
        end else begin
          seen[cand_data] <= 1'b1;
          index           <= index + 1'b1;
          // The last free slot just filled: index wraps to zero naturally
          if (index == LAST_IDX) begin
            state     <= READY;
            busy      <= 1'b0;
            done_sbox <= 1'b1;
          end
        end
      end
    end
  end

endmodule
